shim_sts_sync_latch: RTL and testbench
======================================

SHIM_STS_SYNC_LATCH -- requirements
Module: shim_sts_sync_latch

Interface
REQ-001 SHALL have parameter N_FLAGS, default 8, status vector width; legal range 1..64.
REQ-002 SHALL have parameter SYNC_DEPTH, default 3, synchronizer flop stages per bit; legal minimum 2.
REQ-003 SHALL have parameter STABLE_COUNT, default 2, consecutive unchanged cycles required before acceptance; legal minimum 1.
REQ-004 SHALL derive IDX_W = max(1, clog2(N_FLAGS)) and CNT_W = clog2(STABLE_COUNT+1).
REQ-005 SHALL have port aclk, input, 1, single clock for all logic.
REQ-006 SHALL have port aresetn, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port sts_in, input, N_FLAGS, raw status flags from the SPI clock domain.
REQ-008 SHALL have port clr, input, N_FLAGS, write-1-to-clear strobe for sts_sticky, aclk domain.
REQ-009 SHALL have port sts_stable, output, N_FLAGS, last accepted stable status word.
REQ-010 SHALL have port sts_sticky, output, N_FLAGS, latched rising flags.
REQ-011 SHALL have port first_idx, output, IDX_W, index of the first flag latched since all-clear.
REQ-012 SHALL have port first_valid, output, 1, qualifies first_idx.
REQ-013 SHALL have port sts_irq, output, 1, one-cycle pulse on any new sticky set.

Function
REQ-014 SHALL pass each sts_in bit through SYNC_DEPTH flops; the last stage is sync_q, and one further register holds sync_prev.
REQ-015 SHALL keep one vector-wide counter cnt: cnt <= 0 when sync_q != sync_prev; else cnt <= cnt+1, saturating at STABLE_COUNT.
REQ-016 SHALL load sts_stable <= sync_q only when cnt == STABLE_COUNT and sync_q == sync_prev; otherwise sts_stable holds its value (it is never forced to zero).
REQ-017 SHALL give an input step held constant a latency of SYNC_DEPTH+STABLE_COUNT+2 rising edges to sts_stable (7 at defaults).
REQ-018 SHALL NOT let an input toggling faster than STABLE_COUNT+1 cycles update sts_stable; sts_stable then holds its prior value.
REQ-019 SHALL compute rise = new sts_stable & ~old sts_stable on each load; this is the set vector for sts_sticky.
REQ-020 SHALL update sts_sticky[i] <= rise[i] | (sts_sticky[i] & ~clr[i]); when set and clr coincide on a bit, set wins.
REQ-021 SHALL pulse sts_irq high for exactly the cycle after any rise bit is 1.
REQ-022 SHALL capture first_idx = lowest set index of rise and first_valid <= 1 when first_valid == 0 and rise != 0.
REQ-023 SHALL leave first_idx and first_valid unchanged on later rises while first_valid == 1.
REQ-024 SHALL clear first_valid (first_idx holds its value) when the next sts_sticky value is all-zero.
REQ-025 SHALL ignore clr bits for flags that are not sticky; clr has no effect on sts_stable.
REQ-026 SHALL compute every output from registers only; no combinational path from sts_in or clr to any output.

Reset
REQ-027 SHALL, while aresetn is low, asynchronously force all sync flops, sync_prev, cnt, sts_stable, sts_sticky, first_idx, first_valid and sts_irq to 0.
REQ-028 SHALL, after reset is released, load the first sts_stable value no earlier than SYNC_DEPTH+STABLE_COUNT+2 edges later; a constant nonzero input then sets sticky and irq as a rise.
REQ-029 SHALL abandon any in-progress stability count on reset asserted mid-operation, with no residual state.

Verification (defaults N_FLAGS=8, SYNC_DEPTH=3, STABLE_COUNT=2)
REQ-030 SHALL check: sts_in 0x00->0x05 held -> sts_stable=0x05 at edge 7, sts_sticky=0x05, first_idx=0, first_valid=1, sts_irq high exactly one cycle.
REQ-031 SHALL check: sts_in bit3 toggled every cycle for 20 cycles -> sts_stable, sts_sticky and sts_irq unchanged throughout.
REQ-032 SHALL check: sticky=0x05, then sts_in 0x05->0x85 -> sticky=0x85, irq pulse, first_idx stays 0.
REQ-033 SHALL check: clr=0x85 for one cycle -> sticky=0x00, first_valid=0; sts_stable still 0x85.
REQ-034 SHALL check: clr[2] in the same cycle as a rise on bit2 -> sticky[2]=1.
REQ-035 SHALL check: aresetn pulsed low mid-count with sts_in=0xFF -> all outputs 0 immediately; sts_stable=0xFF at edge 7 after release, first_idx=0.

Source files
------------

// File: rtl/shim_sts_sync_latch.sv
// Status-flag shim: synchronizes SPI-domain flags, debounces them, and latches rising flags with first-index capture.
// Latency: a held input step reaches sts_stable after SYNC_DEPTH+STABLE_COUNT+2 edges; no backpressure, sampled every cycle.
module shim_sts_sync_latch #(
    parameter int N_FLAGS      = 8,
    parameter int SYNC_DEPTH   = 3,
    parameter int STABLE_COUNT = 2,
    localparam int IDX_W       = (N_FLAGS > 1) ? $clog2(N_FLAGS) : 1,
    localparam int CNT_W       = $clog2(STABLE_COUNT + 1)
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [N_FLAGS-1:0] sts_in,
    input  logic [N_FLAGS-1:0] clr,
    output logic [N_FLAGS-1:0] sts_stable,
    output logic [N_FLAGS-1:0] sts_sticky,
    output logic [IDX_W-1:0]   first_idx,
    output logic               first_valid,
    output logic               sts_irq
);

    logic [N_FLAGS-1:0] sync_ff_q [SYNC_DEPTH];
    logic [N_FLAGS-1:0] sync_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_FLAGS-1:0] stable_q, stable_d;
    logic [N_FLAGS-1:0] sticky_q, sticky_d;
    logic [IDX_W-1:0]   first_idx_q, first_idx_d;
    logic               first_valid_q, first_valid_d;
    logic               irq_q, irq_d;

    logic [N_FLAGS-1:0] sync_last;
    logic               load;
    logic [N_FLAGS-1:0] rise;
    logic [IDX_W-1:0]   low_idx;

    assign sync_last = sync_ff_q[SYNC_DEPTH-1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int s = 0; s < SYNC_DEPTH; s++) begin
                sync_ff_q[s] <= '0;
            end
        end else begin
            sync_ff_q[0] <= sts_in;
            for (int s = 1; s < SYNC_DEPTH; s++) begin
                sync_ff_q[s] <= sync_ff_q[s-1];
            end
        end
    end

    // Accept only after the synchronized word has been unchanged for STABLE_COUNT+1 compares.
    always_comb begin
        cnt_d = cnt_q;
        if (sync_last != sync_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STABLE_COUNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign load = (cnt_q == CNT_W'(STABLE_COUNT)) && (sync_last == sync_prev_q);

    always_comb begin
        stable_d = stable_q;
        rise     = '0;
        if (load) begin
            stable_d = sync_last;
            rise     = sync_last & ~stable_q;
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = N_FLAGS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // A set on the same cycle as its clear wins, so no rising edge is lost.
    always_comb begin
        sticky_d      = rise | (sticky_q & ~clr);
        irq_d         = |rise;
        first_idx_d   = first_idx_q;
        first_valid_d = first_valid_q;
        if (sticky_d == '0) begin
            first_valid_d = 1'b0;
        end else if (!first_valid_q && (rise != '0)) begin
            first_valid_d = 1'b1;
            first_idx_d   = low_idx;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_prev_q   <= '0;
            cnt_q         <= '0;
            stable_q      <= '0;
            sticky_q      <= '0;
            first_idx_q   <= '0;
            first_valid_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            sync_prev_q   <= sync_last;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            sticky_q      <= sticky_d;
            first_idx_q   <= first_idx_d;
            first_valid_q <= first_valid_d;
            irq_q         <= irq_d;
        end
    end

    assign sts_stable  = stable_q;
    assign sts_sticky  = sticky_q;
    assign first_idx   = first_idx_q;
    assign first_valid = first_valid_q;
    assign sts_irq     = irq_q;

endmodule

// File: tb/tb_shim_sts_sync_latch.sv
// Bench for shim_sts_sync_latch: directed scenarios with literal expectations plus randomized traffic against a window model.
module tb_shim_sts_sync_latch;

    localparam int N  = 8;
    localparam int D  = 3;
    localparam int SC = 2;
    localparam int HW = D + SC + 2;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [N-1:0] sts_in = '0;
    logic [N-1:0] clr = '0;
    logic [N-1:0] sts_stable;
    logic [N-1:0] sts_sticky;
    logic [2:0]   first_idx;
    logic         first_valid;
    logic         sts_irq;

    shim_sts_sync_latch #(.N_FLAGS(N), .SYNC_DEPTH(D), .STABLE_COUNT(SC)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .sts_in      (sts_in),
        .clr         (clr),
        .sts_stable  (sts_stable),
        .sts_sticky  (sts_sticky),
        .first_idx   (first_idx),
        .first_valid (first_valid),
        .sts_irq     (sts_irq)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word is accepted once SC+2 consecutive input samples, seen D edges late, all agree.
    logic [N-1:0] hist [HW];
    logic [N-1:0] m_stable = '0;
    logic [N-1:0] m_sticky = '0;
    logic [2:0]   m_idx = '0;
    logic         m_fv = 1'b0;
    logic         m_irq = 1'b0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int j = 0; j < HW; j++) hist[j] = '0;
            m_stable = '0;
            m_sticky = '0;
            m_idx    = '0;
            m_fv     = 1'b0;
            m_irq    = 1'b0;
        end else begin
            logic         all_eq;
            logic [N-1:0] r;
            for (int j = HW - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = sts_in;
            all_eq = 1'b1;
            for (int j = D + 1; j < HW; j++) if (hist[j] != hist[D]) all_eq = 1'b0;
            r = '0;
            if (all_eq) begin
                r        = hist[D] & ~m_stable;
                m_stable = hist[D];
            end
            m_sticky = r | (m_sticky & ~clr);
            m_irq    = (r != '0);
            if (m_sticky == '0) begin
                m_fv = 1'b0;
            end else if (!m_fv && r != '0) begin
                m_fv = 1'b1;
                for (int i = N - 1; i >= 0; i--) if (r[i]) m_idx = 3'(i);
            end
        end
    end

    always @(negedge aclk) begin
        if (chk_en) begin
            chk("model_stable", sts_stable, m_stable);
            chk("model_sticky", sts_sticky, m_sticky);
            chk("model_first_valid", first_valid, m_fv);
            if (m_fv) chk("model_first_idx", first_idx, m_idx);
            chk("model_irq", sts_irq, m_irq);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stable"}, sts_stable, 0);
        chk({tag, "_sticky"}, sts_sticky, 0);
        chk({tag, "_idx"}, first_idx, 0);
        chk({tag, "_fv"}, first_valid, 0);
        chk({tag, "_irq"}, sts_irq, 0);
    endtask

    initial begin
        int irq_cnt;
        aresetn = 1'b0;
        sts_in  = '0;
        clr     = '0;
        cyc(1);
        chk_all_zero("reset");
        chk_en  = 1'b1;
        aresetn = 1'b1;
        cyc(10);

        // 0x00 -> 0x05 step
        sts_in = 8'h05;
        cyc(6);
        chk("step_edge6_stable", sts_stable, 8'h00);
        cyc(1);
        chk("step_edge7_stable", sts_stable, 8'h05);
        chk("step_sticky", sts_sticky, 8'h05);
        chk("step_idx", first_idx, 0);
        chk("step_fv", first_valid, 1);
        chk("step_irq_on", sts_irq, 1);
        cyc(1);
        chk("step_irq_off", sts_irq, 0);

        // fast toggle on bit3 must never be accepted
        for (int i = 0; i < 20; i++) begin
            sts_in = sts_in ^ 8'h08;
            cyc(1);
            chk("toggle_stable", sts_stable, 8'h05);
            chk("toggle_sticky", sts_sticky, 8'h05);
            chk("toggle_irq", sts_irq, 0);
        end
        cyc(8);

        // later rise keeps first index
        sts_in  = 8'h85;
        irq_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            irq_cnt += int'(sts_irq);
        end
        chk("rise2_irq_pulses", irq_cnt, 1);
        chk("rise2_sticky", sts_sticky, 8'h85);
        chk("rise2_idx", first_idx, 0);
        chk("rise2_fv", first_valid, 1);

        // clear everything
        clr = 8'h85;
        cyc(1);
        clr = '0;
        chk("clr_sticky", sts_sticky, 8'h00);
        chk("clr_fv", first_valid, 0);
        chk("clr_stable", sts_stable, 8'h85);
        chk("clr_idx_hold", first_idx, 0);

        // set wins over a coincident clear on bit2
        sts_in = 8'h81;
        cyc(12);
        chk("drop2_stable", sts_stable, 8'h81);
        sts_in = 8'h85;
        cyc(6);
        clr = 8'h04;
        cyc(1);
        clr = '0;
        chk("setwins_stable", sts_stable, 8'h85);
        chk("setwins_sticky", sts_sticky, 8'h04);
        chk("setwins_idx", first_idx, 2);
        chk("setwins_fv", first_valid, 1);
        cyc(4);

        // reset mid-count
        sts_in = 8'hFF;
        cyc(3);
        #2 aresetn = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge aclk);
        aresetn = 1'b1;
        cyc(6);
        chk("rst_edge6_stable", sts_stable, 8'h00);
        cyc(1);
        chk("rst_edge7_stable", sts_stable, 8'hFF);
        chk("rst_sticky", sts_sticky, 8'hFF);
        chk("rst_idx", first_idx, 0);
        chk("rst_fv", first_valid, 1);
        chk("rst_irq", sts_irq, 1);

        // randomized traffic against the model
        for (int seg = 0; seg < 300; seg++) begin
            int hold;
            case ($urandom_range(0, 3))
                0:       sts_in = sts_in ^ (8'h01 << $urandom_range(0, 7));
                1:       sts_in = '0;
                default: sts_in = 8'($urandom);
            endcase
            hold = $urandom_range(1, 10);
            for (int k = 0; k < hold; k++) begin
                clr = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
                cyc(1);
            end
            clr = '0;
            if ($urandom_range(0, 39) == 0) begin
                #3 aresetn = 1'b0;
                cyc($urandom_range(1, 2));
                aresetn = 1'b1;
            end
        end
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
